// File: rtl/hh_sched_pkg.sv
// Shared FSM state encoding and datapath phase codes for the HH step scheduler.
package hh_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_G0,
    ST_M0,
    ST_G1,
    ST_M1,
    ST_STDP,
    ST_FIN
  } state_t;

  localparam logic [1:0] PH_GATE = 2'd0;
  localparam logic [1:0] PH_MEM  = 2'd1;
  localparam logic [1:0] PH_STDP = 2'd2;

endpackage

// File: rtl/tick_divider.sv
// Integration tick generator: counts 0..DT_DIV-1 while enabled, ticks on the last count.
module tick_divider #(
  parameter int unsigned DT_DIV = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CW = (DT_DIV > 1) ? $clog2(DT_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DT_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/hh_step_scheduler.sv
// Time-multiplexes the shared HH datapath between the pre/post neurons each step
// and issues an STDP op when a spike pair lands inside the learning window.
module hh_step_scheduler
  import hh_sched_pkg::*;
#(
  parameter int unsigned DT_DIV = 16,
  parameter int unsigned WIN    = 8,
  parameter int unsigned AGE_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [7:0]       i_stim,
  output logic [7:0]       stim_q,
  output logic             dp_start,
  output logic             dp_sel,
  output logic [1:0]       dp_phase,
  input  logic             dp_done,
  input  logic             dp_spike,
  output logic [1:0]       spike,
  output logic             stdp_dir,
  output logic [AGE_W-1:0] stdp_dt,
  output logic [15:0]      step_cnt,
  output logic             busy,
  output logic             overrun
);

  localparam logic [AGE_W-1:0] WIN_A = AGE_W'(WIN);

  state_t           state_q;
  logic [7:0]       stim_lat_q;
  logic             start_q, sel_q, dir_q, busy_q, ovr_q, s0_q, s1_q;
  logic [1:0]       phase_q, spike_q;
  logic [AGE_W-1:0] dt_q, age0_q, age1_q, age0_d, age1_d;
  logic [15:0]      cnt_q;
  logic             tick, accept;
  logic             stdp_hit_d, dir_d;
  logic [AGE_W-1:0] dt_d;

  tick_divider #(.DT_DIV(DT_DIV)) u_tick (
    .clk_i  (clk),
    .rst_i  (rst),
    .en_i   (en),
    .tick_o (tick)
  );

  // done is only honoured once the start pulse has dropped
  assign accept = dp_done && !start_q;

  // Evaluated at M1 completion: dp_spike is the post neuron's flag for this step.
  always_comb begin
    stdp_hit_d = 1'b0;
    dir_d      = 1'b0;
    dt_d       = '0;
    if (s0_q && dp_spike) begin
      stdp_hit_d = 1'b1;
      dir_d      = 1'b1;
    end else if (dp_spike && (age0_q < WIN_A)) begin
      stdp_hit_d = 1'b1;
      dir_d      = 1'b1;
      dt_d       = age0_q + AGE_W'(1);
    end else if (s0_q && (age1_q < WIN_A)) begin
      stdp_hit_d = 1'b1;
      dt_d       = age1_q + AGE_W'(1);
    end
  end

  always_comb begin
    age0_d = s0_q ? '0 : ((age0_q == '1) ? age0_q : age0_q + AGE_W'(1));
    age1_d = s1_q ? '0 : ((age1_q == '1) ? age1_q : age1_q + AGE_W'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      stim_lat_q <= '0;
      start_q    <= 1'b0;
      sel_q      <= 1'b0;
      phase_q    <= PH_GATE;
      dir_q      <= 1'b0;
      dt_q       <= '0;
      spike_q    <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      ovr_q      <= 1'b0;
      s0_q       <= 1'b0;
      s1_q       <= 1'b0;
      age0_q     <= '1;
      age1_q     <= '1;
    end else begin
      if (tick && (state_q != ST_IDLE)) ovr_q <= 1'b1;
      if (start_q) start_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (tick) begin
          stim_lat_q <= i_stim;
          busy_q     <= 1'b1;
          s0_q       <= 1'b0;
          s1_q       <= 1'b0;
          start_q    <= 1'b1;
          sel_q      <= 1'b0;
          phase_q    <= PH_GATE;
          state_q    <= ST_G0;
        end
        ST_G0: if (accept) begin
          start_q <= 1'b1;
          phase_q <= PH_MEM;
          state_q <= ST_M0;
        end
        ST_M0: if (accept) begin
          s0_q    <= dp_spike;
          start_q <= 1'b1;
          sel_q   <= 1'b1;
          phase_q <= PH_GATE;
          state_q <= ST_G1;
        end
        ST_G1: if (accept) begin
          start_q <= 1'b1;
          phase_q <= PH_MEM;
          state_q <= ST_M1;
        end
        ST_M1: if (accept) begin
          s1_q <= dp_spike;
          if (stdp_hit_d) begin
            start_q <= 1'b1;
            sel_q   <= 1'b0;
            phase_q <= PH_STDP;
            dir_q   <= dir_d;
            dt_q    <= dt_d;
            state_q <= ST_STDP;
          end else begin
            state_q <= ST_FIN;
          end
        end
        ST_STDP: if (accept) state_q <= ST_FIN;
        ST_FIN: begin
          spike_q <= {s1_q, s0_q};
          age0_q  <= age0_d;
          age1_q  <= age1_d;
          cnt_q   <= cnt_q + 16'd1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stim_q   = stim_lat_q;
  assign dp_start = start_q;
  assign dp_sel   = sel_q;
  assign dp_phase = phase_q;
  assign spike    = spike_q;
  assign stdp_dir = dir_q;
  assign stdp_dt  = dt_q;
  assign step_cnt = cnt_q;
  assign busy     = busy_q;
  assign overrun  = ovr_q;

endmodule

// File: tb/tb_hh_step_scheduler.sv
// Scoreboard bench for hh_step_scheduler: directed steps push expected ops and
// step-end results; a negedge monitor pops and compares as the DUT presents them.
module tb_hh_step_scheduler;

  // DT_DIV 24 leaves room for an 18/22-cycle step at latency 3 while a latency of 6
  // (30-cycle step) still overruns.
  localparam int unsigned DT_DIV = 24;
  localparam int unsigned WIN    = 8;
  localparam int unsigned AGE_W  = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             en = 1'b0;
  logic [7:0]       i_stim = 8'h00;
  logic [7:0]       stim_q;
  logic             dp_start, dp_sel;
  logic [1:0]       dp_phase;
  logic             dp_done = 1'b0;
  logic             dp_spike = 1'b0;
  logic [1:0]       spike;
  logic             stdp_dir;
  logic [AGE_W-1:0] stdp_dt;
  logic [15:0]      step_cnt;
  logic             busy, overrun;

  always #5 clk = ~clk;

  hh_step_scheduler #(.DT_DIV(DT_DIV), .WIN(WIN), .AGE_W(AGE_W)) dut (
    .clk(clk), .rst(rst), .en(en), .i_stim(i_stim), .stim_q(stim_q),
    .dp_start(dp_start), .dp_sel(dp_sel), .dp_phase(dp_phase),
    .dp_done(dp_done), .dp_spike(dp_spike), .spike(spike),
    .stdp_dir(stdp_dir), .stdp_dt(stdp_dt), .step_cnt(step_cnt),
    .busy(busy), .overrun(overrun)
  );

  typedef struct {
    logic       sel;
    logic [1:0] ph;
    logic       dir;
    logic [7:0] dt;
  } op_t;

  typedef struct {
    logic [1:0]  spk;
    logic [15:0] cnt;
    logic [7:0]  stim;
  } end_t;

  op_t  opq[$];
  end_t endq[$];
  op_t  mon_op;
  end_t mon_end;

  int   errors = 0;
  int   checks = 0;
  int   lat = 3;
  int   cd = 0;
  logic cap_sel = 1'b0;
  logic [1:0] cap_ph = 2'd0;
  logic p0 = 1'b0, p1 = 1'b0;
  logic prev_busy = 1'b0, prev_start = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Datapath model: done (with spike in membrane phases) arrives lat cycles after start.
  always @(negedge clk) begin
    dp_done  = 1'b0;
    dp_spike = 1'b0;
    if (rst) begin
      cd = 0;
    end else begin
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          dp_done  = 1'b1;
          dp_spike = (cap_ph == 2'd1) && (cap_sel ? p1 : p0);
        end
      end
      if (dp_start) begin
        cd      = lat;
        cap_sel = dp_sel;
        cap_ph  = dp_phase;
      end
    end
  end

  // Monitor: pops on each start pulse and on each busy falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (dp_start) begin
        chk("start_width", {31'd0, prev_start}, 32'd0);
        if (opq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: sel=%0d phase=%0d, no op expected", dp_sel, dp_phase);
        end else begin
          mon_op = opq.pop_front();
          chk("op_sel", {31'd0, dp_sel}, {31'd0, mon_op.sel});
          chk("op_phase", {30'd0, dp_phase}, {30'd0, mon_op.ph});
          if (mon_op.ph == 2'd2) begin
            chk("stdp_dir", {31'd0, stdp_dir}, {31'd0, mon_op.dir});
            chk("stdp_dt", {24'd0, stdp_dt}, {24'd0, mon_op.dt});
          end
        end
      end
      if (prev_busy && !busy) begin
        if (endq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_end: step_cnt=%0d, no step end expected", step_cnt);
        end else begin
          mon_end = endq.pop_front();
          chk("end_spike", {30'd0, spike}, {30'd0, mon_end.spk});
          chk("end_step_cnt", {16'd0, step_cnt}, {16'd0, mon_end.cnt});
          chk("end_stim_q", {24'd0, stim_q}, {24'd0, mon_end.stim});
        end
      end
    end
    prev_busy  = busy;
    prev_start = dp_start;
  end

  task automatic push_op(input logic sel, input logic [1:0] ph, input logic dir, input logic [7:0] dt);
    op_t o;
    o = '{sel: sel, ph: ph, dir: dir, dt: dt};
    opq.push_back(o);
  endtask

  task automatic wait_end();
    int n = 0;
    while (busy !== 1'b1 && n < 300) begin @(negedge clk); n++; end
    while (busy === 1'b1 && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      checks++;
      errors++;
      $display("FAIL step_timeout: busy=%b after %0d cycles, required step completion", busy, n);
    end
  endtask

  task automatic do_step(input logic n0, input logic n1, input logic [7:0] stim, input logic [15:0] cnt,
                         input logic stdp, input logic dir, input logic [7:0] dt);
    end_t e;
    p0     = n0;
    p1     = n1;
    i_stim = stim;
    push_op(1'b0, 2'd0, 1'b0, 8'd0);
    push_op(1'b0, 2'd1, 1'b0, 8'd0);
    push_op(1'b1, 2'd0, 1'b0, 8'd0);
    push_op(1'b1, 2'd1, 1'b0, 8'd0);
    if (stdp) push_op(1'b0, 2'd2, dir, dt);
    e = '{spk: {n1, n0}, cnt: cnt, stim: stim};
    endq.push_back(e);
    wait_end();
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    chk("rst_stim_q", {24'd0, stim_q}, 32'd0);
    chk("rst_dp_start", {31'd0, dp_start}, 32'd0);
    chk("rst_dp_sel", {31'd0, dp_sel}, 32'd0);
    chk("rst_dp_phase", {30'd0, dp_phase}, 32'd0);
    chk("rst_spike", {30'd0, spike}, 32'd0);
    chk("rst_stdp_dir", {31'd0, stdp_dir}, 32'd0);
    chk("rst_stdp_dt", {24'd0, stdp_dt}, 32'd0);
    chk("rst_step_cnt", {16'd0, step_cnt}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_overrun", {31'd0, overrun}, 32'd0);

    // Plain steps, potentiation (n0@3,n1@5), depression (n1@5,n0@7), tie (@8).
    en = 1'b1;
    do_step(1'b0, 1'b0, 8'h20, 16'd1, 1'b0, 1'b0, 8'd0);
    do_step(1'b0, 1'b0, 8'h20, 16'd2, 1'b0, 1'b0, 8'd0);
    do_step(1'b1, 1'b0, 8'h20, 16'd3, 1'b0, 1'b0, 8'd0);
    do_step(1'b0, 1'b0, 8'h20, 16'd4, 1'b0, 1'b0, 8'd0);
    do_step(1'b0, 1'b1, 8'h20, 16'd5, 1'b1, 1'b1, 8'd2);
    do_step(1'b0, 1'b0, 8'h20, 16'd6, 1'b0, 1'b0, 8'd0);
    do_step(1'b1, 1'b0, 8'h20, 16'd7, 1'b1, 1'b0, 8'd2);
    do_step(1'b1, 1'b1, 8'h20, 16'd8, 1'b1, 1'b1, 8'd0);

    // Reset while G1 is waiting for done.
    p0 = 1'b0;
    p1 = 1'b0;
    push_op(1'b0, 2'd0, 1'b0, 8'd0);
    push_op(1'b0, 2'd1, 1'b0, 8'd0);
    push_op(1'b1, 2'd0, 1'b0, 8'd0);
    n = 0;
    while (!(dp_start === 1'b1 && dp_sel === 1'b1 && dp_phase === 2'd0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("g1_reached", {31'd0, n >= 300}, 32'd0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("midrst_dp_start", {31'd0, dp_start}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_step_cnt", {16'd0, step_cnt}, 32'd0);
    chk("midrst_spike", {30'd0, spike}, 32'd0);
    chk("midrst_stim_q", {24'd0, stim_q}, 32'd0);
    chk("midrst_ops_issued", opq.size(), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Ages saturated by reset: a lone n0 spike must not trigger STDP.
    do_step(1'b1, 1'b0, 8'h5A, 16'd1, 1'b0, 1'b0, 8'd0);
    for (int k = 2; k <= 9; k++) do_step(1'b0, 1'b0, 8'h5A, 16'(k), 1'b0, 1'b0, 8'd0);
    // n1 spikes 9 steps after n0: age0 == WIN, outside the window.
    do_step(1'b0, 1'b1, 8'h5A, 16'd10, 1'b0, 1'b0, 8'd0);
    chk("no_overrun_yet", {31'd0, overrun}, 32'd0);

    // Slow datapath: next tick lands while busy.
    lat = 6;
    do_step(1'b0, 1'b0, 8'h5A, 16'd11, 1'b0, 1'b0, 8'd0);
    chk("overrun_set", {31'd0, overrun}, 32'd1);
    do_step(1'b0, 1'b0, 8'h5A, 16'd12, 1'b0, 1'b0, 8'd0);
    chk("overrun_sticky", {31'd0, overrun}, 32'd1);

    repeat (4) @(negedge clk);
    chk("ops_left", opq.size(), 32'd0);
    chk("ends_left", endq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
